// File: rtl/pwm_decoder.sv
// pwm_decoder: measures period and high time of an asynchronous PWM input,
// reporting constant-level inputs by timeout through a valid/ready output register.
module pwm_decoder #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 2**WIDTH-1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cg,
    input  logic             i_pwm,
    output logic [WIDTH-1:0] o_periodCount,
    output logic [WIDTH-1:0] o_highCount,
    output logic             o_constLevel,
    output logic             o_constHigh,
    output logic             o_overrun,
    output logic             o_valid,
    input  logic             i_ready
);
    typedef enum logic {SEARCH, MEASURE} state_t;
    localparam logic [WIDTH-1:0] TMO = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [WIDTH-1:0]       period_ctr_q, period_ctr_d, high_ctr_q, high_ctr_d;
    logic [WIDTH-1:0]       period_q, period_d, high_q, high_d;
    logic                   const_q, const_d, const_high_q, const_high_d;
    logic                   overrun_q, overrun_d, valid_q, valid_d;
    logic                   s, rise, timeout, emit, load;

    always_comb begin
        s            = sync_q[SYNC_STAGES-1];
        rise         = s & ~prev_q;
        timeout      = ~rise && (period_ctr_q == TMO);
        // a rise in SEARCH closes only a partial period, so it is never reported
        emit         = timeout || (rise && state_q == MEASURE);
        load         = emit && (!valid_q || i_ready);
        sync_d       = {sync_q[SYNC_STAGES-2:0], i_pwm};
        prev_d       = s;
        state_d      = rise ? MEASURE : timeout ? SEARCH : state_q;
        period_ctr_d = (rise || timeout) ? ONE : period_ctr_q + ONE;
        high_ctr_d   = rise ? ONE
                     : (state_q == MEASURE && !timeout) ? high_ctr_q + WIDTH'(s)
                     : high_ctr_q;
        period_d     = !load ? period_q : timeout ? TMO : period_ctr_q;
        high_d       = !load ? high_q : timeout ? (s ? TMO : '0) : high_ctr_q;
        const_d      = load ? timeout : const_q;
        const_high_d = load ? (timeout & s) : const_high_q;
        valid_d      = load || (valid_q && !i_ready);
        overrun_d    = load ? 1'b0 : emit ? 1'b1 : i_ready ? 1'b0 : overrun_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= SEARCH;
            sync_q       <= '0;
            prev_q       <= 1'b0;
            period_ctr_q <= '0;
            high_ctr_q   <= '0;
            period_q     <= '0;
            high_q       <= '0;
            const_q      <= 1'b0;
            const_high_q <= 1'b0;
            overrun_q    <= 1'b0;
            valid_q      <= 1'b0;
        end else if (i_cg) begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            prev_q       <= prev_d;
            period_ctr_q <= period_ctr_d;
            high_ctr_q   <= high_ctr_d;
            period_q     <= period_d;
            high_q       <= high_d;
            const_q      <= const_d;
            const_high_q <= const_high_d;
            overrun_q    <= overrun_d;
            valid_q      <= valid_d;
        end
    end

    assign o_periodCount = period_q;
    assign o_highCount   = high_q;
    assign o_constLevel  = const_q;
    assign o_constHigh   = const_high_q;
    assign o_overrun     = overrun_q;
    assign o_valid       = valid_q;
endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: directed bench for pwm_decoder with TIMEOUT=100 and hand-computed
// result timing; inputs change 1 time unit after each rising edge, outputs read there.
module tb_pwm_decoder;
    localparam int W  = 16;
    localparam int TO = 100;

    logic         i_clk = 1'b0, i_rst_n = 1'b1, i_cg = 1'b1, i_pwm = 1'b0, i_ready = 1'b1;
    logic [W-1:0] o_periodCount, o_highCount;
    logic         o_constLevel, o_constHigh, o_overrun, o_valid;
    int checks = 0, failures = 0;
    int mode = 0, per = 10, hi = 3, ph = 0, n = 0;

    pwm_decoder #(.WIDTH(W), .SYNC_STAGES(2), .TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cg(i_cg), .i_pwm(i_pwm),
        .o_periodCount(o_periodCount), .o_highCount(o_highCount),
        .o_constLevel(o_constLevel), .o_constHigh(o_constHigh),
        .o_overrun(o_overrun), .o_valid(o_valid), .i_ready(i_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // mode 0 = constant low, 1 = constant high, 2 = PWM with period per and high time hi
    task automatic cyc();
        i_pwm = (mode == 2) ? (ph < hi) : (mode == 1);
        ph = (ph + 1 == per) ? 0 : ph + 1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic res(input string tag, input int p, input int h, input int c, input int ch, input int ov);
        chk({tag, "_valid"}, o_valid, 1);
        chk({tag, "_period"}, o_periodCount, p);
        chk({tag, "_high"}, o_highCount, h);
        chk({tag, "_const"}, o_constLevel, c);
        chk({tag, "_consthigh"}, o_constHigh, ch);
        chk({tag, "_overrun"}, o_overrun, ov);
    endtask

    task automatic zeros(input string tag);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_period"}, o_periodCount, 0);
        chk({tag, "_high"}, o_highCount, 0);
        chk({tag, "_const"}, o_constLevel, 0);
        chk({tag, "_consthigh"}, o_constHigh, 0);
        chk({tag, "_overrun"}, o_overrun, 0);
    endtask

    task automatic wait_valid(input string tag, input int maxc, output int cnt);
        cnt = 0;
        do begin
            cyc();
            cnt++;
        end while (o_valid !== 1'b1 && cnt < maxc);
        chk({tag, "_seen"}, o_valid, 1);
    endtask

    initial begin
        #1 i_rst_n = 1'b0;
        repeat (3) cyc();
        zeros("reset");
        i_rst_n = 1'b1;
        wait_valid("lo1", 200, n);
        chk("lo1_latency", n, 101);
        res("lo1", TO, 0, 1, 0, 0);
        wait_valid("lo2", 200, n);
        chk("lo2_interval", n, 100);
        res("lo2", TO, 0, 1, 0, 0);
        mode = 2; per = 10; hi = 3; ph = 0;
        wait_valid("pwm1", 50, n);
        chk("pwm1_latency", n, 13);
        res("pwm1", 10, 3, 0, 0, 0);
        repeat (3) begin
            wait_valid("pwm_n", 50, n);
            chk("pwm_n_interval", n, 10);
            res("pwm_n", 10, 3, 0, 0, 0);
        end
        while (ph != 0) cyc();
        mode = 1;
        wait_valid("last", 50, n);
        chk("last_latency", n, 3);
        res("last", 10, 3, 0, 0, 0);
        wait_valid("hi1", 200, n);
        chk("hi1_interval", n, 100);
        res("hi1", TO, TO, 1, 1, 0);
        wait_valid("hi2", 200, n);
        chk("hi2_interval", n, 100);
        res("hi2", TO, TO, 1, 1, 0);
        mode = 0;
        repeat (5) cyc();
        mode = 2; hi = 5; ph = 0; i_ready = 1'b0;
        wait_valid("ov1", 50, n);
        chk("ov1_latency", n, 13);
        res("ov1", 10, 5, 0, 0, 0);
        repeat (12) cyc();
        res("ov_held", 10, 5, 0, 0, 1);
        i_ready = 1'b1;
        cyc();
        chk("ov_xfer_valid", o_valid, 0);
        chk("ov_xfer_overrun", o_overrun, 0);
        wait_valid("ov2", 50, n);
        chk("ov2_latency", n, 7);
        res("ov2", 10, 5, 0, 0, 0);
        i_ready = 1'b0; hi = 7;
        repeat (9) cyc();
        res("same_pend", 10, 5, 0, 0, 0);
        i_ready = 1'b1;
        cyc();
        res("same_load", 10, 7, 0, 0, 0);
        per = 20; hi = 5; i_ready = 1'b0;
        repeat (5) cyc();
        i_cg = 1'b0; i_ready = 1'b1;
        repeat (7) cyc();
        res("cg_hold", 10, 7, 0, 0, 0);
        i_cg = 1'b1;
        cyc();
        chk("cg_xfer_valid", o_valid, 0);
        wait_valid("cg", 50, n);
        chk("cg_latency", n, 7);
        res("cg", 13, 5, 0, 0, 0);
        i_ready = 1'b0;
        repeat (3) cyc();
        i_rst_n = 1'b0;
        #1;
        zeros("rst_mid");
        cyc();
        i_rst_n = 1'b1; i_ready = 1'b1;
        wait_valid("rst", 80, n);
        chk("rst_latency", n, 36);
        res("rst", 20, 5, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
